// File: rtl/vector_gen.sv
// rtl/vector_gen.sv - stepping binary/Gray stimulus-vector generator with wrap and done flags
module vector_gen #(
    parameter int unsigned WIDTH = 9,
    parameter int unsigned STEP  = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic [1:0]       mode,
    input  logic             one_shot,
    output logic [WIDTH-1:0] vec,
    output logic             wrapped,
    output logic             done
);

    localparam logic [1:0] MODE_DOWN = 2'b01;
    localparam logic [1:0] MODE_GRAY = 2'b10;
    localparam logic [1:0] MODE_HOLD = 2'b11;

    localparam logic [WIDTH:0] STEP_W = (WIDTH + 1)'(STEP);

    generate
        if (WIDTH < 1 || WIDTH > 32) begin : g_bad_width
            $error("vector_gen: WIDTH must be in 1..32");
        end
        if (STEP < 1 || 64'(STEP) > ((64'd1 << WIDTH) - 64'd1)) begin : g_bad_step
            $error("vector_gen: STEP must be in 1..2^WIDTH-1");
        end
    endgenerate

    logic [WIDTH-1:0] cnt;
    logic [WIDTH-1:0] cnt_next;
    logic             wrapped_next;
    logic             done_next;
    logic [WIDTH:0]   sum;
    logic [WIDTH:0]   diff;
    logic             stepping;

    // The extra top bit of sum/diff is the carry/borrow that marks a boundary crossing.
    always_comb begin
        sum          = {1'b0, cnt} + STEP_W;
        diff         = {1'b0, cnt} - STEP_W;
        stepping     = en && (mode != MODE_HOLD) && !(done && one_shot);
        cnt_next     = cnt;
        wrapped_next = 1'b0;
        done_next    = done;
        if (stepping) begin
            if (mode == MODE_DOWN) begin
                if (diff[WIDTH]) begin
                    wrapped_next = 1'b1;
                    done_next    = 1'b1;
                    if (!one_shot) begin
                        cnt_next = diff[WIDTH-1:0];
                    end
                end else begin
                    cnt_next = diff[WIDTH-1:0];
                end
            end else begin
                if (sum[WIDTH]) begin
                    wrapped_next = 1'b1;
                    done_next    = 1'b1;
                    if (!one_shot) begin
                        cnt_next = sum[WIDTH-1:0];
                    end
                end else begin
                    cnt_next = sum[WIDTH-1:0];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt     <= '0;
            wrapped <= 1'b0;
            done    <= 1'b0;
        end else if (load) begin
            cnt     <= load_val;
            wrapped <= 1'b0;
            done    <= 1'b0;
        end else begin
            cnt     <= cnt_next;
            wrapped <= wrapped_next;
            done    <= done_next;
        end
    end

    always_comb begin
        vec = cnt;
        if (mode == MODE_GRAY) begin
            vec = cnt ^ (cnt >> 1);
        end
    end

endmodule

// File: tb/tb_vector_gen.sv
// tb/tb_vector_gen.sv - randomized and directed bench for vector_gen against an arithmetic model
module tb_vector_gen;

    localparam int W    = 9;
    localparam int SPAN = 1 << W;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         en = 1'b0;
    logic         load = 1'b0;
    logic [W-1:0] load_val = '0;
    logic [1:0]   mode = 2'b00;
    logic         one_shot = 1'b0;

    logic [W-1:0] vec_a, vec_b;
    logic         wrapped_a, wrapped_b;
    logic         done_a, done_b;

    int n_checks = 0;
    int n_fail   = 0;

    int step_of [2] = '{1, 3};
    int m_cnt   [2];
    int m_wrap  [2];
    int m_done  [2];

    always #5 clk = ~clk;

    vector_gen #(.WIDTH(W), .STEP(1)) u_dut_a (
        .clk(clk), .rst(rst), .en(en), .load(load), .load_val(load_val),
        .mode(mode), .one_shot(one_shot),
        .vec(vec_a), .wrapped(wrapped_a), .done(done_a)
    );

    vector_gen #(.WIDTH(W), .STEP(3)) u_dut_b (
        .clk(clk), .rst(rst), .en(en), .load(load), .load_val(load_val),
        .mode(mode), .one_shot(one_shot),
        .vec(vec_b), .wrapped(wrapped_b), .done(done_b)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference: plain integer arithmetic over the 2^W count space.
    task automatic model_edge();
        for (int i = 0; i < 2; i++) begin
            if (rst) begin
                m_cnt[i] = 0; m_wrap[i] = 0; m_done[i] = 0;
            end else if (load) begin
                m_cnt[i] = int'(load_val); m_wrap[i] = 0; m_done[i] = 0;
            end else if (en && mode != 2'b11 && !(m_done[i] != 0 && one_shot)) begin
                int n;
                n = (mode == 2'b01) ? m_cnt[i] - step_of[i] : m_cnt[i] + step_of[i];
                if (n < 0 || n >= SPAN) begin
                    m_wrap[i] = 1;
                    m_done[i] = 1;
                    if (!one_shot) m_cnt[i] = (n + SPAN) % SPAN;
                end else begin
                    m_cnt[i]  = n;
                    m_wrap[i] = 0;
                end
            end else begin
                m_wrap[i] = 0;
            end
        end
    endtask

    function automatic int exp_vec(int i);
        return (mode == 2'b10) ? (m_cnt[i] ^ (m_cnt[i] >> 1)) : m_cnt[i];
    endfunction

    task automatic compare_all();
        check("vec_a", 32'(vec_a), 32'(exp_vec(0)));
        check("wrapped_a", 32'(wrapped_a), 32'(m_wrap[0]));
        check("done_a", 32'(done_a), 32'(m_done[0]));
        check("vec_b", 32'(vec_b), 32'(exp_vec(1)));
        check("wrapped_b", 32'(wrapped_b), 32'(m_wrap[1]));
        check("done_b", 32'(done_b), 32'(m_done[1]));
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
        compare_all();
    endtask

    initial begin
        // Reset
        rst = 1'b1;
        tick();
        check("reset_vec", 32'(vec_a), 32'd0);
        rst = 1'b0;

        // Exhaustive up sweep with wrap
        mode = 2'b00; en = 1'b1; one_shot = 1'b0;
        repeat (SPAN) tick();
        check("up_wrap_vec", 32'(vec_a), 32'd0);
        check("up_wrap_pulse", 32'(wrapped_a), 32'd1);
        tick();
        check("up_pulse_once", 32'(wrapped_a), 32'd0);
        check("up_done_sticky", 32'(done_a), 32'd1);

        // One-shot sweep freezes at the top
        rst = 1'b1; tick(); rst = 1'b0;
        one_shot = 1'b1;
        repeat (SPAN) tick();
        check("os_vec", 32'(vec_a), 32'd511);
        check("os_pulse", 32'(wrapped_a), 32'd1);
        repeat (5) tick();
        check("os_frozen_vec", 32'(vec_a), 32'd511);
        check("os_no_pulse", 32'(wrapped_a), 32'd0);

        // Load beats step and clears done
        one_shot = 1'b0; load = 1'b1; load_val = 9'h1F0;
        tick();
        check("load_vec", 32'(vec_a), 32'h1F0);
        check("load_done_clr", 32'(done_a), 32'd0);
        load = 1'b0;
        repeat (16) tick();
        check("load_sweep_wrap", 32'(vec_a), 32'd0);
        check("load_sweep_pulse", 32'(wrapped_a), 32'd1);

        // Down underflow with STEP=3, then Gray encoding
        load = 1'b1; load_val = 9'd2; tick();
        load = 1'b0; mode = 2'b01; tick();
        check("down_wrap_vec_b", 32'(vec_b), 32'd511);
        check("down_wrap_pulse_b", 32'(wrapped_b), 32'd1);
        mode = 2'b10; #1;
        check("gray_immediate_a", 32'(vec_a), 32'(m_cnt[0] ^ (m_cnt[0] >> 1)));
        load = 1'b1; load_val = 9'd6; tick();
        check("gray_load_a", 32'(vec_a), 32'd5);
        load = 1'b0; tick();
        check("gray_step_a", 32'(vec_a), 32'd4);

        // Hold and idle
        mode = 2'b11; repeat (10) tick();
        mode = 2'b00; en = 1'b0; repeat (10) tick();

        // Mid-sweep reset
        en = 1'b1; load = 1'b1; load_val = 9'd300; tick();
        load = 1'b0; rst = 1'b1; tick();
        check("midrst_vec", 32'(vec_a), 32'd0);
        check("midrst_done", 32'(done_a), 32'd0);
        rst = 1'b0;

        // Randomized traffic
        for (int k = 0; k < 4000; k++) begin
            rst      = ($urandom_range(0, 127) == 0);
            load     = ($urandom_range(0, 31) == 0);
            load_val = W'($urandom);
            en       = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 15) == 0) mode = 2'($urandom);
            if ($urandom_range(0, 63) == 0) one_shot = ~one_shot;
            tick();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
